// File: rtl/bpb_update_sched.sv
// ---------------------------------------------------------------------------
// bpb_update_sched
//
// Commit-side update scheduler for the branch prediction buffer (BPB).
// The dual-issue commit stage can resolve two branches per cycle, while the
// BPB has a single write port. This block queues resolved-branch updates in
// program order in a small dual-push / single-pop circular FIFO. It drains
// one entry per non-stalled cycle onto the BPB write port.
//
// Commit never waits on this block. When the FIFO has no room, updates are
// dropped and counted, because prediction state is only a hint.
//
// Parameters
//   DEPTH          FIFO entries (power of two, >= 2)
//   DROP_W         width of the saturating drop counter
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   stall          pipeline stall; the BPB ignores wen while high
//   flush          discard every queued update
//   upd_valid[1:0] per-slot resolved-branch strobe (slot 0 is older)
//   upd_pc         {slot1 pc, slot0 pc}, 32 bits each
//   upd_taken[1:0] resolved direction per slot
//   upd_destpc     {slot1 target, slot0 target}, 32 bits each
//   wen            BPB write request (head entry valid)
//   pc_commit      head branch PC (0 when empty)
//   destpc_commit  head {taken, destpc} (0 when empty)
//   count          occupied entries
//   drop_cnt       dropped updates, saturating, cleared only by reset
//   busy           count != 0
// ---------------------------------------------------------------------------
module bpb_update_sched #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        upd_valid,
  input  logic [63:0]       upd_pc,
  input  logic [1:0]        upd_taken,
  input  logic [63:0]       upd_destpc,
  output logic              wen,
  output logic [31:0]       pc_commit,
  output logic [32:0]       destpc_commit,
  output logic [CNT_W-1:0]  count,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  // Entry layout: [64:33] pc, [32] taken, [31:0] destpc.
  localparam int ENTRY_W = 65;

  // -------------------------------------------------------------------------
  // Storage and state
  // -------------------------------------------------------------------------
  logic [ENTRY_W-1:0] entry_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_reg,   rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg,   wr_ptr_next;
  logic [CNT_W-1:0]  count_reg,    count_next;
  logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;

  // Per-slot packed entries built from the flat input buses.
  logic [ENTRY_W-1:0] slot_entry [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign slot_entry[gi] = {upd_pc[32*gi +: 32], upd_taken[gi], upd_destpc[32*gi +: 32]};
  end

  // -------------------------------------------------------------------------
  // Head presentation
  // -------------------------------------------------------------------------
  logic [ENTRY_W-1:0] head_entry;

  assign head_entry = entry_mem[rd_ptr_reg];
  assign wen        = (count_reg != '0);
  assign busy       = wen;
  assign count      = count_reg;
  assign drop_cnt   = drop_cnt_reg;

  // Entry contents are not reset, so mask the head while the queue is empty.
  assign pc_commit     = wen ? head_entry[64:33] : 32'h0;
  assign destpc_commit = wen ? head_entry[32:0]  : 33'h0;

  // -------------------------------------------------------------------------
  // Push / pop accounting
  // -------------------------------------------------------------------------
  logic               pop;
  logic [CNT_W:0]     free_slots;
  logic [1:0]         n_req;
  logic [1:0]         acc_raw;
  logic [1:0]         accepted;
  logic [1:0]         dropped;

  // The BPB consumes the write under exactly this condition.
  assign pop = wen & ~stall;

  // A same-cycle pop frees its slot for the incoming updates. That makes a
  // push at full possible.
  assign free_slots = (CNT_W+1)'(DEPTH) - {1'b0, count_reg} + (CNT_W+1)'(pop);

  assign n_req = {1'b0, upd_valid[0]} + {1'b0, upd_valid[1]};

  always_comb begin
    acc_raw = n_req;
    if ((CNT_W+1)'(n_req) > free_slots) begin
      acc_raw = free_slots[1:0];
    end
  end

  // A flush discards same-cycle pushes outright, so they are not drops.
  assign accepted = flush ? 2'd0 : acc_raw;
  assign dropped  = flush ? 2'd0 : (n_req - acc_raw);

  // -------------------------------------------------------------------------
  // Write ports
  // Port A always takes the oldest accepted update. That is slot 0 if valid,
  // otherwise slot 1. Port B only carries slot 1 when both are accepted.
  // With one free slot and both valid, slot 0 wins.
  // -------------------------------------------------------------------------
  logic               wr_a_en,   wr_b_en;
  logic [PTR_W-1:0]   wr_a_addr, wr_b_addr;
  logic [ENTRY_W-1:0] wr_a_data;

  assign wr_a_en   = (accepted != 2'd0);
  assign wr_b_en   = (accepted == 2'd2);
  assign wr_a_addr = wr_ptr_reg;
  assign wr_b_addr = wr_ptr_reg + PTR_W'(1);
  assign wr_a_data = upd_valid[0] ? slot_entry[0] : slot_entry[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_a_en) begin
        entry_mem[wr_a_addr] <= wr_a_data;
      end
      if (wr_b_en) begin
        entry_mem[wr_b_addr] <= slot_entry[1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic [DROP_W:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt_reg} + (DROP_W+1)'(dropped);

  always_comb begin
    rd_ptr_next   = rd_ptr_reg + PTR_W'(pop);
    wr_ptr_next   = wr_ptr_reg + PTR_W'(accepted);
    count_next    = count_reg + CNT_W'(accepted) - CNT_W'(pop);
    drop_cnt_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    if (flush) begin
      // The queue becomes empty by collapsing the read pointer onto the
      // write pointer. The head shown this cycle may still be written by
      // the BPB.
      rd_ptr_next = wr_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      drop_cnt_reg <= '0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

endmodule

// File: tb/tb_bpb_update_sched.sv
// ---------------------------------------------------------------------------
// tb_bpb_update_sched
//
// Directed-vector bench for bpb_update_sched with DEPTH = 4 and DROP_W = 16.
// Stimulus pushes each update it expects to be accepted into a queue. A
// monitor pops one entry and compares it on every BPB write
// (wen & ~stall). Occupancy, drop counter and empty outputs are checked
// directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_bpb_update_sched;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [1:0]  upd_valid;
  logic [63:0] upd_pc;
  logic [1:0]  upd_taken;
  logic [63:0] upd_destpc;
  logic        wen;
  logic [31:0] pc_commit;
  logic [32:0] destpc_commit;
  logic [2:0]  count;
  logic [15:0] drop_cnt;
  logic        busy;

  bpb_update_sched #(.DEPTH(4), .DROP_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_destpc    (upd_destpc),
    .wen           (wen),
    .pc_commit     (pc_commit),
    .destpc_commit (destpc_commit),
    .count         (count),
    .drop_cnt      (drop_cnt),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] dest;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  // Downstream BPB 2-bit state for pc 0x300.
  // Encoding: taken moves 00->01->11, not-taken moves 11->10->00.
  logic [1:0] bpb_state = 2'b00;
  int         writes_300 = 0;

  function automatic logic [1:0] bpb_step(input logic [1:0] s, input logic tk);
    logic [1:0] n;
    case (s)
      2'b00:   n = tk ? 2'b01 : 2'b00;
      2'b01:   n = tk ? 2'b11 : 2'b00;
      2'b11:   n = tk ? 2'b11 : 2'b10;
      default: n = tk ? 2'b11 : 2'b00;
    endcase
    return n;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wen && !stall) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual pc=%h dest=%h required no write", pc_commit, destpc_commit);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (pc_commit !== e.pc || destpc_commit !== {e.tk, e.dest}) begin
            errors++;
            $display("FAIL write_order actual pc=%h dest=%h required pc=%h dest=%h",
                     pc_commit, destpc_commit, e.pc, {e.tk, e.dest});
          end else begin
            $display("write pc=%h taken=%0d dest=%h", pc_commit, destpc_commit[32], destpc_commit[31:0]);
          end
        end
        if (pc_commit == 32'h300) begin
          bpb_state = bpb_step(bpb_state, destpc_commit[32]);
          writes_300++;
        end
      end else if (!wen) begin
        checks++;
        if (pc_commit !== 32'h0 || destpc_commit !== 33'h0) begin
          errors++;
          $display("FAIL empty_head actual pc=%h dest=%h required 0", pc_commit, destpc_commit);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("check %s = %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_valid  = 2'b00;
    upd_pc     = 64'h0;
    upd_taken  = 2'b00;
    upd_destpc = 64'h0;
  endtask

  // Drive both slots. acc marks which slots the bench expects to be queued.
  task automatic upd(input logic [1:0] v, input logic [1:0] acc,
                     input logic [31:0] pc0, input logic tk0, input logic [31:0] d0,
                     input logic [31:0] pc1, input logic tk1, input logic [31:0] d1);
    exp_t e;
    upd_valid  = v;
    upd_pc     = {pc1, pc0};
    upd_taken  = {tk1, tk0};
    upd_destpc = {d1, d0};
    if (acc[0]) begin
      e.pc = pc0; e.tk = tk0; e.dest = d0;
      exp_q.push_back(e);
    end
    if (acc[1]) begin
      e.pc = pc1; e.tk = tk1; e.dest = d1;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    idle();
    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset state.
    chk("reset_wen", 32'(wen), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("reset_pc_commit", pc_commit, 32'd0);
    chk("reset_destpc", destpc_commit[31:0], 32'd0);

    // Single update, one-cycle latency, then empty.
    upd(2'b01, 2'b01, 32'hBFC00010, 1'b1, 32'hBFC00100, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
    chk("single_wen", 32'(wen), 32'd1);
    chk("single_count", 32'(count), 32'd1);
    tick();
    chk("single_after_wen", 32'(wen), 32'd0);
    chk("single_after_count", 32'(count), 32'd0);

    // Dual push, drains over two cycles.
    upd(2'b11, 2'b11, 32'h100, 1'b0, 32'h1100, 32'h200, 1'b1, 32'h1200);
    tick();
    idle();
    chk("dual_count_2", 32'(count), 32'd2);
    tick();
    chk("dual_count_1", 32'(count), 32'd1);
    tick();
    chk("dual_count_0", 32'(count), 32'd0);

    // Only slot 1 valid.
    upd(2'b10, 2'b10, 32'h0, 1'b0, 32'h0, 32'h250, 1'b1, 32'h1250);
    tick();
    idle();
    chk("slot1_count", 32'(count), 32'd1);
    tick();
    chk("slot1_drained", 32'(count), 32'd0);

    // Stalled: three dual-update cycles into a depth-4 queue.
    stall = 1'b1;
    upd(2'b11, 2'b11, 32'h400, 1'b1, 32'h1400, 32'h401, 1'b0, 32'h1401);
    tick();
    chk("stall_count_a", 32'(count), 32'd2);
    upd(2'b11, 2'b11, 32'h402, 1'b1, 32'h1402, 32'h403, 1'b0, 32'h1403);
    tick();
    chk("stall_count_b", 32'(count), 32'd4);
    upd(2'b11, 2'b00, 32'h404, 1'b1, 32'h1404, 32'h405, 1'b0, 32'h1405);
    tick();
    idle();
    chk("stall_count_full", 32'(count), 32'd4);
    chk("stall_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("stall_wen_held", 32'(wen), 32'd1);
    chk("stall_head_held", pc_commit, 32'h400);

    // Full with pop: slot 0 accepted, slot 1 dropped.
    stall = 1'b0;
    upd(2'b11, 2'b01, 32'h500, 1'b1, 32'h1500, 32'h501, 1'b0, 32'h1501);
    tick();
    idle();
    chk("full_pop_count", 32'(count), 32'd4);
    chk("full_pop_drop_cnt", 32'(drop_cnt), 32'd3);
    repeat (4) tick();
    chk("full_drained", 32'(count), 32'd0);

    // Same pc, three separate updates in order.
    upd(2'b11, 2'b11, 32'h300, 1'b1, 32'h1300, 32'h300, 1'b1, 32'h1300);
    tick();
    upd(2'b01, 2'b01, 32'h300, 1'b0, 32'h1300, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
    repeat (3) tick();
    chk("dup_drained", 32'(count), 32'd0);
    chk("dup_writes", 32'(writes_300), 32'd3);
    chk("dup_bpb_state", 32'(bpb_state), 32'd2);

    // Flush at count 3 with a simultaneous push.
    stall = 1'b1;
    upd(2'b11, 2'b11, 32'h600, 1'b1, 32'h1600, 32'h601, 1'b0, 32'h1601);
    tick();
    upd(2'b01, 2'b01, 32'h602, 1'b1, 32'h1602, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
    chk("preflush_count", 32'(count), 32'd3);
    stall = 1'b0;
    flush = 1'b1;
    upd(2'b11, 2'b00, 32'h700, 1'b1, 32'h1700, 32'h701, 1'b1, 32'h1701);
    tick();
    idle();
    flush = 1'b0;
    // The flush-cycle head (0x600) went to the BPB; 0x601/0x602 are gone.
    chk("flush_head_written", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_wen", 32'(wen), 32'd0);
    chk("flush_drop_cnt", 32'(drop_cnt), 32'd3);
    tick();
    chk("flush_stays_empty", 32'(count), 32'd0);

    // Drop counter saturation: fill, then drop two per cycle well past 2^16.
    stall = 1'b1;
    upd(2'b11, 2'b11, 32'h800, 1'b0, 32'h1800, 32'h801, 1'b1, 32'h1801);
    tick();
    upd(2'b11, 2'b11, 32'h802, 1'b0, 32'h1802, 32'h803, 1'b1, 32'h1803);
    tick();
    chk("sat_fill_count", 32'(count), 32'd4);
    upd(2'b11, 2'b00, 32'h8F0, 1'b1, 32'h18F0, 32'h8F1, 1'b1, 32'h18F1);
    repeat (32768) tick();
    chk("sat_drop_cnt", 32'(drop_cnt), 32'hFFFF);
    tick();
    chk("sat_drop_cnt_hold", 32'(drop_cnt), 32'hFFFF);
    chk("sat_count", 32'(count), 32'd4);

    // Reset mid-operation with live inputs.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    exp_q.delete();
    chk("midreset_count", 32'(count), 32'd0);
    chk("midreset_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("midreset_wen", 32'(wen), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);

    // Normal operation after reset.
    stall = 1'b0;
    upd(2'b01, 2'b01, 32'h900, 1'b1, 32'h1900, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
    chk("post_reset_count", 32'(count), 32'd1);
    tick();
    chk("post_reset_drained", 32'(count), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpb_update_sched.md
# bpb_update_sched

Commit-side update scheduler for the branch prediction buffer. The dual-issue commit stage resolves up to two branches per cycle, but each BPB line has a single write port (`pc_commit`, `wen`, `destpc_commit`) that is gated by `stall`. This block queues resolved-branch updates in program order in a small dual-push / single-pop FIFO and drains one per non-stalled cycle to the BPB write port. It drops updates on overflow, because prediction state is a hint and commit never back-pressures.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2
- `DROP_W`, 16, width of saturating drop counter
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  pipeline stall; BPB ignores `wen` while high
- `flush`  in  1  discard all queued updates (predictor disable / reconfigure)
- `upd_valid`  in  2  per-slot resolved-branch strobe; slot 0 is older
- `upd_pc`  in  2×32  branch PC per slot
- `upd_taken`  in  2  resolved direction per slot
- `upd_destpc`  in  2×32  resolved target per slot
- `wen`  out  1  BPB write request (head valid)
- `pc_commit`  out  32  head branch PC
- `destpc_commit`  out  bpb_result_t  head {taken, destpc}
- `count`  out  $clog2(DEPTH)+1  occupied entries
- `drop_cnt`  out  DROP_W  dropped updates, saturating
- `busy`  out  1  `count != 0`

## Operation
- Storage: circular buffer with `rd_ptr` and `wr_ptr` of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a `count` register. Each entry holds {pc, taken, destpc}.
- Outputs are combinational from the head entry:
  - `wen = (count != 0)`.
  - `pc_commit` and `destpc_commit` = entry[rd_ptr].
  - When empty they are 0, with `destpc_commit.taken = 0`.
- Pop: `pop = wen & ~stall`. This is the same condition under which the BPB consumes the write. `rd_ptr` advances by 1.
- Push accounting:
  - `free = DEPTH - count + pop`.
  - `n_req` = number of set `upd_valid` bits.
  - Accepted = min(`n_req`, `free`).
- Ordering and drop policy:
  - Slot 0 is always enqueued before slot 1.
  - If only one slot is valid, it takes the first free position.
  - If `free == 1` and both are valid, slot 0 is accepted and slot 1 is dropped.
  - If `free == 0`, all valid updates are dropped.
- `drop_cnt` adds the number dropped each cycle and saturates at all-ones; it is cleared only by reset.
- Duplicate PCs are never merged. Every update reaches the BPB in order, because the 2-bit counter semantics depend on each event.
- `flush`:
  - Next state: `count = 0`, pointers equal; same-cycle pushes are discarded and not counted as drops.
  - The head visible during the flush cycle is still presented on `wen`. If `stall = 0`, the BPB writes it; this is expected.
- `count` update: `count_next = count + accepted - pop`. `count` never exceeds DEPTH and never underflows.

## Timing
- Reset: `count = 0`, `rd_ptr = wr_ptr = 0`, `drop_cnt = 0`. Hence `wen = 0`, `busy = 0`, `pc_commit = 0`, `destpc_commit = 0`. Entry contents need no reset.
- Latency: an update accepted at edge N appears on the write port in cycle N+1 at the earliest (empty queue). There is no same-cycle bypass.
- Throughput: at most one BPB write per non-stalled cycle; up to two enqueues per cycle.
- Stall: head and `wen` hold steady and no pop occurs. Pushes continue until full, then drop.
- Simultaneous push and pop at full: the pop frees one slot in the same cycle, so one update is accepted.
- Reset mid-operation: the queue is emptied and `drop_cnt` is cleared on that edge; all inputs in the reset cycle are ignored.

## Test plan
- Reset, then slot 0 = {pc 0xBFC00010, taken 1, dest 0xBFC00100}, `stall = 0` → next cycle `wen = 1` with those values; the following cycle `wen = 0`, `count = 0`.
- Both slots valid in one cycle (pcs 0x100, 0x200), `stall = 0` → writes appear in two consecutive cycles, 0x100 then 0x200; `count` goes 2 → 1 → 0.
- Hold `stall = 1`; issue 3 cycles of dual updates (6 total, DEPTH 4) → `count = 4`, `drop_cnt = 2`. The first four pcs drain in order once stall drops.
- Queue full (count 4), `stall = 0`, both slots valid → slot 0 accepted, slot 1 dropped; `count` stays 4; `drop_cnt` increments by 1.
- Same pc 0x300 updated taken, taken, not-taken → three separate writes in order; the downstream BPB state sequence is 00→01→11→10.
- `count = 3` with `flush` and a simultaneous push → next cycle `count = 0`, `wen = 0`, `drop_cnt` unchanged. Also force `drop_cnt` to 0xFFFF and overflow → it stays 0xFFFF.
